// File: rtl/adxl345_pkg.sv
// Shared ADXL345 register map, scheduler state encoding and burst-size constant
// used by the sample scheduler and its testbench.
package adxl345_pkg;

  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam logic [2:0] AXIS_BYTES = 3'd6;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_CFG_FMT,
    S_CFG_RATE,
    S_CFG_PWR,
    S_IDLE,
    S_RD_CMD,
    S_RD_DATA,
    S_PUBLISH
  } sched_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: counts 0..DIV-1 from reset release and emits a
// single-cycle tick while the count sits at its last value.
module sample_tick_gen #(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adxl345_sample_scheduler.sv
// Sole SPI command issuer for the ADXL345: power-up wait, three configuration
// writes, then periodic 6-byte axis bursts published as one coherent sample.
module adxl345_sample_scheduler
  import adxl345_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 1_000_000,
  parameter int unsigned POWERUP_CYCLES = 200_000,
  parameter logic [3:0]  RATE_CODE      = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        format_sel,
  input  logic        measure_en,
  input  logic        cfg_update,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic        cmd_mb,
  output logic [5:0]  cmd_addr,
  output logic [7:0]  cmd_wdata,
  output logic [2:0]  cmd_len,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        txn_done,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned PW_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

  sched_state_t    state, next_state;
  logic [PW_W-1:0] pw_cnt;
  logic            tick;
  logic            wait_done;
  logic            cmd_hold;
  logic [7:0]      wdata_q;
  logic [7:0]      live_wdata;
  logic            cfg_pending;
  logic            clear_pending;
  logic [2:0]      byte_idx;
  logic [7:0]      shadow [AXIS_BYTES];

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Write data follows the live switches on the first presented cycle, then
  // stays frozen until the engine accepts the command.
  assign cmd_wdata = cmd_hold ? wdata_q : live_wdata;

  always_comb begin
    next_state    = state;
    cmd_valid     = 1'b0;
    cmd_rw        = 1'b0;
    cmd_mb        = 1'b0;
    cmd_addr      = 6'h00;
    cmd_len       = 3'd0;
    live_wdata    = 8'h00;
    sample_valid  = 1'b0;
    clear_pending = 1'b0;
    case (state)
      S_PWR_WAIT: begin
        if (pw_cnt == PW_W'(POWERUP_CYCLES - 1)) next_state = S_CFG_FMT;
      end
      S_CFG_FMT: begin
        cmd_valid  = !wait_done;
        cmd_addr   = REG_DATA_FORMAT;
        cmd_len    = 3'd1;
        live_wdata = {4'b0000, format_sel, 3'b000};
        if (wait_done && txn_done) next_state = S_CFG_RATE;
      end
      S_CFG_RATE: begin
        cmd_valid  = !wait_done;
        cmd_addr   = REG_BW_RATE;
        cmd_len    = 3'd1;
        live_wdata = {4'b0000, RATE_CODE};
        if (wait_done && txn_done) next_state = S_CFG_PWR;
      end
      S_CFG_PWR: begin
        cmd_valid  = !wait_done;
        cmd_addr   = REG_POWER_CTL;
        cmd_len    = 3'd1;
        live_wdata = {4'b0000, measure_en, 3'b000};
        if (wait_done && txn_done) next_state = S_IDLE;
      end
      S_IDLE: begin
        // A coincident cfg_update counts as pending and outranks the tick.
        if (cfg_pending || cfg_update) begin
          next_state    = S_CFG_FMT;
          clear_pending = 1'b1;
        end else if (tick) begin
          next_state = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_mb    = 1'b1;
        cmd_addr  = REG_DATAX0;
        cmd_len   = AXIS_BYTES;
        if (cmd_ready) next_state = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (txn_done) next_state = (byte_idx == AXIS_BYTES) ? S_PUBLISH : S_IDLE;
      end
      S_PUBLISH: begin
        sample_valid = 1'b1;
        next_state   = S_IDLE;
      end
      default: next_state = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_PWR_WAIT;
      busy        <= 1'b0;
      pw_cnt      <= '0;
      wait_done   <= 1'b0;
      cmd_hold    <= 1'b0;
      wdata_q     <= 8'h00;
      cfg_pending <= 1'b0;
      overrun     <= 1'b0;
      byte_idx    <= 3'd0;
      x_data      <= 16'h0000;
      y_data      <= 16'h0000;
      z_data      <= 16'h0000;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      if (state == S_PWR_WAIT) pw_cnt <= pw_cnt + 1'b1;

      if (state != next_state) wait_done <= 1'b0;
      else if (cmd_valid && cmd_ready) wait_done <= 1'b1;

      if (cmd_valid && cmd_ready) begin
        cmd_hold <= 1'b0;
      end else if (cmd_valid && !cmd_hold) begin
        cmd_hold <= 1'b1;
        wdata_q  <= live_wdata;
      end

      if (clear_pending) cfg_pending <= 1'b0;
      else if (cfg_update) cfg_pending <= 1'b1;

      // Ticks are dropped, not queued, whenever the bus is already in use.
      if (tick && state != S_IDLE && state != S_PWR_WAIT) overrun <= 1'b1;

      if (state == S_RD_CMD) begin
        byte_idx <= 3'd0;
      end else if (state == S_RD_DATA && rx_valid && byte_idx < AXIS_BYTES) begin
        byte_idx <= byte_idx + 1'b1;
      end

      if (state == S_RD_DATA && txn_done && byte_idx == AXIS_BYTES) begin
        x_data <= {shadow[1], shadow[0]};
        y_data <= {shadow[3], shadow[2]};
        z_data <= {shadow[5], shadow[4]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RD_DATA && rx_valid && byte_idx < AXIS_BYTES) begin
      shadow[byte_idx] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_adxl345_sample_scheduler.sv
// Directed-sequence bench with randomized responder timing and data; expected
// samples and command timing come from tick arithmetic and a byte-level model.
module tb_adxl345_sample_scheduler;

  localparam int DIV      = 100;
  localparam int PU       = 40;
  localparam int WAIT_MAX = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        format_sel, measure_en, cfg_update;
  logic        cmd_valid, cmd_ready, cmd_rw, cmd_mb;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [2:0]  cmd_len;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        txn_done;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid, overrun, busy;

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  logic [7:0]  resp [8];
  logic [15:0] ref_x = 16'h0, ref_y = 16'h0, ref_z = 16'h0;

  adxl345_sample_scheduler #(
    .SAMPLE_DIV     (DIV),
    .POWERUP_CYCLES (PU),
    .RATE_CODE      (4'hA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .format_sel   (format_sel),
    .measure_en   (measure_en),
    .cfg_update   (cfg_update),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_mb       (cmd_mb),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_len      (cmd_len),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .txn_done     (txn_done),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; ticks land on multiples of DIV.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) resp[i] = 8'($urandom);
  endtask

  // Play the SPI engine for one transaction and check everything it exposes.
  task automatic serve(input string tag, input logic is_rd, input logic [5:0] ea,
                       input logic [7:0] ed, input int exp_start, input int nbytes,
                       input int cfg_byte, input int gap_lo, input int gap_hi,
                       output int start);
    int n;
    int rdy;
    logic full;
    logic [19:0] exp_vec;
    n = 0;
    while (cmd_valid !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_seen"}, 32'(cmd_valid), 1);
    start = cyc;
    if (exp_start >= 0) check_output({tag, "_start"}, start, exp_start);
    exp_vec = {1'b1, is_rd, is_rd, ea, (is_rd ? 8'h00 : ed), (is_rd ? 3'd6 : 3'd1)};
    check_output({tag, "_cmd"},
                 {cmd_valid, cmd_rw, cmd_mb, cmd_addr, (is_rd ? 8'h00 : cmd_wdata), cmd_len},
                 exp_vec);
    rdy = $urandom_range(3, 0);
    repeat (rdy) begin
      @(negedge clk);
      check_output({tag, "_hold"},
                   {cmd_valid, cmd_rw, cmd_mb, cmd_addr, (is_rd ? 8'h00 : cmd_wdata), cmd_len},
                   exp_vec);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_output({tag, "_drop"}, 32'(cmd_valid), 0);
    for (int i = 0; i < nbytes; i++) begin
      repeat (gap_lo + $urandom_range(gap_hi - gap_lo, 0)) @(negedge clk);
      rx_valid   = 1'b1;
      rx_byte    = resp[i];
      cfg_update = (i == cfg_byte);
      @(negedge clk);
      rx_valid   = 1'b0;
      cfg_update = 1'b0;
    end
    @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    if (is_rd) begin
      full = (nbytes >= 6);
      if (full) begin
        ref_x = {resp[1], resp[0]};
        ref_y = {resp[3], resp[2]};
        ref_z = {resp[5], resp[4]};
      end
      check_output({tag, "_sv"}, 32'(sample_valid), 32'(full));
      check_output({tag, "_x"}, 32'(x_data), 32'(ref_x));
      check_output({tag, "_y"}, 32'(y_data), 32'(ref_y));
      check_output({tag, "_z"}, 32'(z_data), 32'(ref_z));
      @(negedge clk);
      check_output({tag, "_sv_end"}, 32'(sample_valid), 0);
    end
  endtask

  task automatic apply_stimulus_config(input string tag, input logic fs, input logic me, input int exp_start);
    int s;
    serve({tag, "_fmt"},  1'b0, 6'h31, {4'h0, fs, 3'b000}, exp_start, 0, -1, 0, 0, s);
    serve({tag, "_rate"}, 1'b0, 6'h2C, 8'h0A,              -1,        0, -1, 0, 0, s);
    serve({tag, "_pwr"},  1'b0, 6'h2D, {4'h0, me, 3'b000}, -1,        0, -1, 0, 0, s);
    check_output({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int s;
    int n;
    rst = 1'b1;
    format_sel = 1'b1;
    measure_en = 1'b1;
    cfg_update = 1'b0;
    cmd_ready = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    txn_done = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_valid", 32'(cmd_valid), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_sv", 32'(sample_valid), 0);
    check_output("rst_ovr", 32'(overrun), 0);
    check_output("rst_xyz", {x_data, y_data | z_data}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_output("pw_busy", 32'(busy), 1);
    check_output("pw_valid", 32'(cmd_valid), 0);

    apply_stimulus_config("boot", 1'b1, 1'b1, PU);
    check_output("idle_valid", 32'(cmd_valid), 0);

    resp[0] = 8'h34; resp[1] = 8'h12; resp[2] = 8'hFF;
    resp[3] = 8'hFF; resp[4] = 8'h00; resp[5] = 8'h80;
    serve("rd1", 1'b1, 6'h32, 8'h00, DIV, 6, -1, 0, 2, s);

    format_sel = 1'b0;
    fill_random();
    serve("rd2", 1'b1, 6'h32, 8'h00, 2 * DIV, 6, 3, 0, 2, s);
    apply_stimulus_config("recfg", 1'b0, 1'b1, -1);
    fill_random();
    serve("rd3", 1'b1, 6'h32, 8'h00, 3 * DIV, 6, -1, 0, 2, s);

    format_sel = 1'b1;
    measure_en = 1'b0;
    n = 0;
    while (cyc != 4 * DIV - 1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check_output("sync", cyc, 4 * DIV - 1);
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    apply_stimulus_config("coinc", 1'b1, 1'b0, 4 * DIV);
    check_output("coinc_ovr", 32'(overrun), 0);
    fill_random();
    serve("rd4", 1'b1, 6'h32, 8'h00, 5 * DIV, 6, -1, 0, 2, s);

    fill_random();
    serve("early", 1'b1, 6'h32, 8'h00, 6 * DIV, 4, -1, 0, 2, s);
    fill_random();
    serve("extra", 1'b1, 6'h32, 8'h00, 7 * DIV, 7, -1, 0, 2, s);
    check_output("pre_ovr", 32'(overrun), 0);

    fill_random();
    serve("stall", 1'b1, 6'h32, 8'h00, 8 * DIV, 6, -1, 25, 25, s);
    check_output("stall_ovr", 32'(overrun), 1);
    fill_random();
    serve("after", 1'b1, 6'h32, 8'h00, 10 * DIV, 6, -1, 0, 2, s);

    n = 0;
    while (cmd_valid !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_start", cyc, 11 * DIV);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      @(negedge clk);
      rx_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    ref_x = 16'h0; ref_y = 16'h0; ref_z = 16'h0;
    check_output("arst_valid", 32'(cmd_valid), 0);
    check_output("arst_busy", 32'(busy), 0);
    check_output("arst_ovr", 32'(overrun), 0);
    check_output("arst_xyz", {x_data, y_data | z_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    format_sel = 1'b1;
    measure_en = 1'b1;
    apply_stimulus_config("reboot", 1'b1, 1'b1, PU);
    fill_random();
    serve("rd5", 1'b1, 6'h32, 8'h00, DIV, 6, -1, 0, 2, s);
    check_output("end_ovr", 32'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adxl345_sample_scheduler.md
Name: adxl345_sample_scheduler

Overview:
Sequences every ADXL345 SPI access. After reset it issues the configuration writes, then triggers a 6-byte burst read of the axis registers at a fixed cadence. It assembles X/Y/Z words and presents one coherent sample to the axis router, FIFO management and UART path. It sits between the control switches and the SPI byte engine and is the only SPI command issuer.

Parameters:
SAMPLE_DIV, 1_000_000, clk cycles between sample triggers (100 Hz at 100 MHz); legal range >= 64.
POWERUP_CYCLES, 200_000, post-reset wait before the first SPI command (2 ms at 100 MHz).
RATE_CODE, 4'hA, BW_RATE[3:0] value written during configuration.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
format_sel  in  1  0: DATA_FORMAT=0x00 (±2g, 10-bit); 1: 0x08 (FULL_RES)
measure_en  in  1  POWER_CTL measure bit value
cfg_update  in  1  single-cycle pulse; request reconfiguration
cmd_valid  out  1  SPI command valid
cmd_ready  in  1  SPI engine accepts command when valid&ready
cmd_rw  out  1  1=read, 0=write
cmd_mb  out  1  multi-byte flag
cmd_addr  out  6  register address
cmd_wdata  out  8  write data byte
cmd_len  out  3  data bytes in transaction (1 or 6)
rx_valid  in  1  one received data byte valid
rx_byte  in  8  received data byte
txn_done  in  1  pulse; transaction complete, CS released
x_data, y_data, z_data  out  16 each  last complete sample, two's complement
sample_valid  out  1  one-cycle pulse when x/y/z update
overrun  out  1  sticky; sample trigger arrived while not IDLE
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release): state=PWR_WAIT; all outputs 0; counters 0.
- Sample tick counter: free-running 0..SAMPLE_DIV-1 from reset release; tick when it wraps. Runs in all states.
- States:
  PWR_WAIT: count POWERUP_CYCLES, then go to CFG_FMT.
  CFG_FMT: write 0x31 <= {4'b0, format_sel, 3'b000}.
  CFG_RATE: write 0x2C <= {4'b0, RATE_CODE}.
  CFG_PWR: write 0x2D <= {4'b0, measure_en, 3'b000}, then go to IDLE.
  IDLE: on pending cfg go to CFG_FMT, else on tick go to RD_CMD.
  RD_CMD: read from 0x32, mb=1, len=6.
  RD_DATA: capture bytes.
  PUBLISH: update x/y/z and pulse sample_valid, then go to IDLE.
- Each CFG_* and RD_CMD: hold cmd_valid and all cmd_* fields stable until handshake. Then deassert cmd_valid the next cycle and wait txn_done before advancing. Single-byte writes: len=1, mb=0, rw=0.
- RD_DATA: byte index 0..5 advances on rx_valid. Order is X0,X1,Y0,Y1,Z0,Z1 into a shadow register. The published words are x={X1,X0}, y={Y1,Y0}, z={Z1,Z0}.
- Advance RD_DATA to PUBLISH only on txn_done with index==6. If txn_done arrives with index<6, discard the shadow, keep outputs, and go to IDLE (no sample_valid). Extra rx_valid beyond 6 bytes are ignored.
- PUBLISH lasts 1 cycle. Latency from txn_done to sample_valid is 1 cycle. x/y/z hold between samples.
- cfg_update: sets cfg_pending from any state. It is cleared on entry to CFG_FMT from IDLE. An in-flight transaction always completes first. In IDLE, cfg_pending has priority over a coincident tick; that tick is not counted as overrun.
- Tick while state not IDLE and not PWR_WAIT sets overrun. The tick is dropped, not queued. overrun clears only on rst.
- format_sel and measure_en are sampled at the cycle their write command is presented.

Decomposition:
- Package adxl345_pkg: register addresses (REG_BW_RATE=6'h2C, REG_POWER_CTL=6'h2D, REG_DATA_FORMAT=6'h31, REG_DATAX0=6'h32), the state enum, and the AXIS_BYTES=6 constant.
- One sub-module, sample_tick_gen: parameterised divider producing a single-cycle tick. All other logic stays in one FSM module.

Test Plan:
- Reset, then POWERUP_CYCLES elapse with format_sel=1 and measure_en=1. Expect three writes in order: (0x31,0x08), (0x2C,0x0A), (0x2D,0x08), each with len=1. Expect busy=0 after the third txn_done.
- Tick in IDLE with responder bytes 0x34,0x12,0xFF,0xFF,0x00,0x80. Expect x=0x1234, y=0xFFFF, z=0x8000, and sample_valid high exactly 1 cycle after txn_done.
- Responder stalls so a read spans more than SAMPLE_DIV cycles. Expect overrun=1, only one read issued, and the next read on the following tick.
- Pulse cfg_update during RD_DATA. The read completes and publishes, then the three config writes run, then sampling resumes. Also pulse cfg_update and a tick in the same IDLE cycle: config runs first and overrun stays 0.
- Early txn_done after 4 bytes: x/y/z are unchanged, no sample_valid, and the next tick reads normally.
- Assert rst mid-RD_DATA. Expect outputs 0, cmd_valid=0 immediately (async), and state PWR_WAIT with the sequence restarting.
